bcd_scan_display: RTL
=====================

# bcd_scan_display

Parametrised, time-multiplexed successor to the static clock/calendar 7-segment decoder. It takes NUM_FIELDS binary fields (seconds, minutes, hours, day, month, year halves, …) and converts each to two BCD digits with a serial shift-add-3 engine, one field at a time. It drives a single shared active-low segment bus plus one-hot active-low digit selects, and supports per-field enable (blank) and per-field blink. It sits between the time/date counters and the board display pins.

## Interface
- NUM_FIELDS, 7, number of 2-digit fields; display has 2*NUM_FIELDS digits
- BIN_W, 7, width of each binary field (1..7)
- SCAN_DIV, 1000, clock cycles per digit slot (≥2)
- BLINK_DIV, 25000000, clock cycles per blink half-period (≥1)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- bin_in  in  NUM_FIELDS*BIN_W  field f at bits [f*BIN_W +: BIN_W]
- field_en  in  NUM_FIELDS  1 = field displayed, 0 = field blanked
- blink_mask  in  NUM_FIELDS  1 = field blanks during blink-off phase
- seg_n  out  7  active-low segments, [0]=a … [6]=g
- dig_sel  out  2*NUM_FIELDS  active-low digit select; bit 2f = units of field f, bit 2f+1 = tens
- upd_done  out  1  one-cycle pulse when a full conversion sweep completes

## Operation
- Converter FSM: IDLE → LOAD → SHIFT → WRITE → LOAD (next field), running continuously after reset.
  - LOAD (1 cycle): snapshot bin_in for field index fi; clear 8-bit BCD accumulator.
  - SHIFT (BIN_W cycles): each cycle add 3 to any BCD nibble ≥5, then shift left one bit, MSB of the snapshot first.
  - WRITE (1 cycle): if the snapshot is ≤99, store {tens, units} in the digit register file; if ≥100, store {0xA, 0xA} (dash). fi wraps NUM_FIELDS-1 → 0; upd_done pulses on the write of field NUM_FIELDS-1.
  - IDLE only occurs for the single cycle after reset.
- Digit code decode: 0–9 → standard glyphs; 0xA → dash (g only); 0xF → blank. Codes 0xB–0xE are unused and decode as blank.
  - Glyphs: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, dash=0x3F, blank=0x7F.
- Scan: cycle counter sc counts 0..SCAN_DIV-1; digit index d advances mod 2*NUM_FIELDS when sc wraps.
- Blink: counter bc counts 0..BLINK_DIV-1; blink_off toggles on each wrap.
- Displayed code for digit d of field f = d/2 is 0xF when field_en[f]=0, or when blink_mask[f]=1 and blink_off=1. Otherwise it is the stored digit.

## Timing
- Reset values:
  - seg_n = 7'h7F, dig_sel = all 1s, upd_done = 0.
  - All digit registers = 0xF.
  - sc, d, bc, fi = 0; blink_off = 0.
- Conversion latency per field: BIN_W+2 cycles (LOAD + BIN_W SHIFT + WRITE). Full sweep: NUM_FIELDS*(BIN_W+2) cycles.
  - First upd_done occurs 1 + NUM_FIELDS*(BIN_W+2) cycles after rst deasserts.
- bin_in is sampled only in LOAD. Changes during SHIFT/WRITE take effect on that field's next sweep.
- seg_n and dig_sel are registered.
  - Slot cycle sc=0 is a guard cycle: dig_sel = all 1s (anti-ghosting).
  - For sc≥1: dig_sel[d]=0, and seg_n shows the decode of digit d, using the register contents and field_en/blink_mask/blink_off from the previous cycle.
- A WRITE to a digit currently being displayed appears on seg_n on the following cycle, with no glitch beyond that one-cycle update.
- field_en and blink_mask changes take effect within 1 cycle and are not tied to slot boundaries.
- Reset asserted mid-sweep or mid-slot returns everything to reset values on the next clock edge. Partial conversion results are discarded.

## Test plan
- Reset: hold rst 5 cycles → seg_n=7'h7F, dig_sel all 1s, upd_done=0. Release with all fields = 0 → after first upd_done, every digit slot shows 0x40.
- Conversion/scan (NUM_FIELDS=2, BIN_W=7, SCAN_DIV=4): field0=59, field1=7 → first upd_done at cycle 19 after release.
  - Slot 0 (dig_sel=4'b1110) shows 0x10; slot 1 (4'b1101) shows 0x12; slot 2 shows 0x78; slot 3 shows 0x40.
  - sc=0 of every slot has dig_sel=4'b1111.
- Overflow and bounds: field0=100 → both digits 0x3F; field0=127 → 0x3F; field0=99 → 0x10, 0x10.
- Blink (BLINK_DIV=8): blink_mask=2'b10, field1=12 → field1 digits alternate 0x24/0x79 and 0x7F every 8 cycles; field0 is never blanked.
  - field_en=2'b01 → field1 digits 0x7F while the dig_sel scan continues unchanged.
- Sampling and reset mid-operation:
  - Change field0 from 59 to 30 during field0's SHIFT → the stored value stays 59 until the next sweep.
  - Assert rst in the middle of a SHIFT → outputs return to reset values next cycle, and the digit registers show blank until a fresh sweep completes.

Source files
------------

// File: rtl/bcd_scan_display_if.sv
// bcd_scan_display_if: bundle between time/date counters and the scanned display.
// Ports: bin_in/field_en/blink_mask toward the display; seg_n/dig_sel/upd_done back.
interface bcd_scan_display_if #(
    parameter int NUM_FIELDS = 7,
    parameter int BIN_W      = 7
);
    logic [NUM_FIELDS*BIN_W-1:0] bin_in;
    logic [NUM_FIELDS-1:0]       field_en;
    logic [NUM_FIELDS-1:0]       blink_mask;
    logic [6:0]                  seg_n;
    logic [2*NUM_FIELDS-1:0]     dig_sel;
    logic                        upd_done;

    modport master (
        output bin_in, field_en, blink_mask,
        input  seg_n, dig_sel, upd_done
    );

    modport slave (
        input  bin_in, field_en, blink_mask,
        output seg_n, dig_sel, upd_done
    );
endinterface

// File: rtl/bcd_scan_display.sv
// bcd_scan_display: serial binary-to-BCD converter feeding a scanned 7-seg display.
// Ports: clk, rst (sync, active-high), bus (slave: fields in, segments/selects out).
module bcd_scan_display #(
    parameter int NUM_FIELDS = 7,
    parameter int BIN_W      = 7,
    parameter int SCAN_DIV   = 1000,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    bcd_scan_display_if.slave bus
);
    localparam int ND = 2 * NUM_FIELDS;
    localparam int FW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int DW = $clog2(ND);
    localparam int CW = $clog2(BIN_W + 1);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, WRITE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             load_en;
    logic             shift_en;
    logic             wr_en;

    logic [FW-1:0]    fi;
    logic [BIN_W-1:0] bin_sel;
    logic [BIN_W-1:0] raw;
    logic [BIN_W-1:0] sreg;
    logic [7:0]       acc;
    logic [7:0]       adj;
    logic [CW-1:0]    cnt;
    logic [3:0]       digs [ND];

    logic [SW-1:0]    sc;
    logic [DW-1:0]    d;
    logic [BW-1:0]    bc;
    logic             blink_off;

    logic [3:0]       cur;
    logic             show;
    logic [3:0]       code;
    logic [6:0]       glyph;

    // ---------------- converter FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  state_nxt = LOAD;
            LOAD:  state_nxt = SHIFT;
            SHIFT: if (cnt == CW'(BIN_W - 1)) state_nxt = WRITE;
            WRITE: state_nxt = LOAD;
        endcase
    end

    always_comb begin
        load_en  = 1'b0;
        shift_en = 1'b0;
        wr_en    = 1'b0;
        unique case (state)
            IDLE:  ;
            LOAD:  load_en  = 1'b1;
            SHIFT: shift_en = 1'b1;
            WRITE: wr_en    = 1'b1;
        endcase
    end

    // ---------------- conversion datapath ----------------
    always_comb begin
        bin_sel = '0;
        for (int i = 0; i < NUM_FIELDS; i++)
            if (fi == FW'(i)) bin_sel = bus.bin_in[i*BIN_W +: BIN_W];
    end

    // Add-3 correction ahead of each shift; a tens overflow only
    // happens for values >= 100, which are replaced by dashes.
    always_comb begin
        adj = acc;
        if (acc[3:0] >= 4'd5) adj[3:0] = acc[3:0] + 4'd3;
        if (acc[7:4] >= 4'd5) adj[7:4] = acc[7:4] + 4'd3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fi           <= '0;
            raw          <= '0;
            sreg         <= '0;
            acc          <= '0;
            cnt          <= '0;
            bus.upd_done <= 1'b0;
            for (int i = 0; i < ND; i++) digs[i] <= 4'hF;
        end else begin
            bus.upd_done <= 1'b0;
            if (load_en) begin
                raw  <= bin_sel;
                sreg <= bin_sel;
                acc  <= '0;
                cnt  <= '0;
            end
            if (shift_en) begin
                acc  <= {adj[6:0], sreg[BIN_W-1]};
                sreg <= sreg << 1;
                cnt  <= cnt + 1'b1;
            end
            if (wr_en) begin
                for (int i = 0; i < NUM_FIELDS; i++) begin
                    if (fi == FW'(i)) begin
                        if (int'(raw) > 99) begin
                            digs[2*i]   <= 4'hA;
                            digs[2*i+1] <= 4'hA;
                        end else begin
                            digs[2*i]   <= acc[3:0];
                            digs[2*i+1] <= acc[7:4];
                        end
                    end
                end
                if (fi == FW'(NUM_FIELDS - 1)) begin
                    fi           <= '0;
                    bus.upd_done <= 1'b1;
                end else begin
                    fi <= fi + 1'b1;
                end
            end
        end
    end

    // ---------------- scan and blink timers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sc <= '0;
            d  <= '0;
        end else if (sc == SW'(SCAN_DIV - 1)) begin
            sc <= '0;
            d  <= (d == DW'(ND - 1)) ? '0 : d + 1'b1;
        end else begin
            sc <= sc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bc        <= '0;
            blink_off <= 1'b0;
        end else if (bc == BW'(BLINK_DIV - 1)) begin
            bc        <= '0;
            blink_off <= ~blink_off;
        end else begin
            bc <= bc + 1'b1;
        end
    end

    // ---------------- display decode ----------------
    always_comb begin
        cur  = 4'hF;
        show = 1'b0;
        for (int i = 0; i < ND; i++) begin
            if (d == DW'(i)) begin
                cur  = digs[i];
                show = bus.field_en[i/2] &
                       ~(bus.blink_mask[i/2] & blink_off);
            end
        end
        code = show ? cur : 4'hF;
    end

    always_comb begin
        case (code)
            4'h0:    glyph = 7'h40;
            4'h1:    glyph = 7'h79;
            4'h2:    glyph = 7'h24;
            4'h3:    glyph = 7'h30;
            4'h4:    glyph = 7'h19;
            4'h5:    glyph = 7'h12;
            4'h6:    glyph = 7'h02;
            4'h7:    glyph = 7'h78;
            4'h8:    glyph = 7'h00;
            4'h9:    glyph = 7'h10;
            4'hA:    glyph = 7'h3F;
            default: glyph = 7'h7F;
        endcase
    end

    // sc == 0 is the guard slot: all digits off while the select moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.seg_n   <= 7'h7F;
            bus.dig_sel <= '1;
        end else if (sc == '0) begin
            bus.seg_n   <= 7'h7F;
            bus.dig_sel <= '1;
        end else begin
            bus.seg_n   <= glyph;
            bus.dig_sel <= ~(ND'(1) << d);
        end
    end
endmodule
